// File: rtl/regfile_sb.sv
// 2-read/1-write register file with write-through bypass and a per-register
// busy scoreboard used by decode to stall on RAW hazards.
module regfile_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ok
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  // Implemented, writable register (excludes out-of-range and hardwired zero).
  function automatic logic is_valid(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
  endfunction

  logic [IDX_W-1:0] a_idx, b_idx, w_idx, i_idx;
  logic             a_ok, b_ok, w_ok, i_ok;
  logic             a_hit, b_hit, i_hit;
  logic [DATA_W-1:0] a_val, b_val;

  assign a_idx = IDX_W'(ra_addr);
  assign b_idx = IDX_W'(rb_addr);
  assign w_idx = IDX_W'(wr_addr);
  assign i_idx = IDX_W'(iss_addr);

  assign a_ok = is_valid(ra_addr);
  assign b_ok = is_valid(rb_addr);
  assign w_ok = is_valid(wr_addr);
  assign i_ok = is_valid(iss_addr);

  // A writeback landing this cycle resolves the hazard and feeds the bypass.
  assign a_hit = wr_en & w_ok & (wr_addr == ra_addr);
  assign b_hit = wr_en & w_ok & (wr_addr == rb_addr);
  assign i_hit = wr_en & w_ok & (wr_addr == iss_addr);

  assign a_val = a_hit ? wr_data : (a_ok ? regs[a_idx] : '0);
  assign b_val = b_hit ? wr_data : (b_ok ? regs[b_idx] : '0);

  assign ra_busy = a_ok & busy[a_idx] & ~a_hit;
  assign rb_busy = b_ok & busy[b_idx] & ~b_hit;
  assign iss_ok  = iss_en & (~i_ok | ~busy[i_idx] | i_hit);

  // Storage and scoreboard; an accepted issue overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_en && w_ok) begin
        regs[w_idx] <= wr_data;
        busy[w_idx] <= 1'b0;
      end
      if (iss_ok && i_ok) busy[i_idx] <= 1'b1;
    end
  end

  // Registered read ports; hold when rd_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data <= '0;
      rb_data <= '0;
    end else if (rd_en) begin
      ra_data <= a_val;
      rb_data <= b_val;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_regfile_sb;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 24;
  localparam bit          ZERO_REG = 1'b1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] ra_addr = '0, rb_addr = '0, wr_addr = '0, iss_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_en = 1'b0, iss_en = 1'b0;
  logic [DATA_W-1:0] ra_data, rb_data;
  logic              ra_busy, rb_busy, iss_ok;

  int n_checks = 0;
  int n_errors = 0;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data), .ra_busy(ra_busy), .rb_busy(rb_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register contents and pending-write flags.
  int unsigned m_reg  [2**ADDR_W];
  bit          m_busy [2**ADDR_W];
  int unsigned m_ra, m_rb;

  function automatic bit ok(input int unsigned a);
    return (a < NUM_REGS) && !(ZERO_REG && a == 0);
  endfunction

  function automatic bit hit(input int unsigned a);
    return wr_en && (int'(wr_addr) == int'(a)) && ok(a);
  endfunction

  function automatic int unsigned rd_val(input int unsigned a);
    if (hit(a)) return int'(wr_data);
    return ok(a) ? m_reg[a] : 0;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_reg[i]) begin m_reg[i] = 0; m_busy[i] = 0; end
      m_ra = 0; m_rb = 0;
    end else begin
      bit e_iss;
      e_iss = iss_en && (!ok(iss_addr) || !m_busy[iss_addr] || hit(iss_addr));
      chk("ra_data", 32'(ra_data), m_ra);
      chk("rb_data", 32'(rb_data), m_rb);
      chk("ra_busy", 32'(ra_busy), 32'(ok(ra_addr) && m_busy[ra_addr] && !hit(ra_addr)));
      chk("rb_busy", 32'(rb_busy), 32'(ok(rb_addr) && m_busy[rb_addr] && !hit(rb_addr)));
      chk("iss_ok", 32'(iss_ok), 32'(e_iss));
      if (rd_en) begin m_ra = rd_val(ra_addr); m_rb = rd_val(rb_addr); end
      if (wr_en && ok(wr_addr)) begin m_reg[wr_addr] = int'(wr_data); m_busy[wr_addr] = 0; end
      if (e_iss && ok(iss_addr)) m_busy[iss_addr] = 1;
    end
  end

  // Drive one cycle of inputs just after the edge, then wait to the sampling edge.
  task automatic step(input bit rd, input int ra, input int rb, input bit we,
                      input int wa, input int wd, input bit ie, input int ia);
    @(posedge clk); #1;
    rd_en = rd; ra_addr = ADDR_W'(ra); rb_addr = ADDR_W'(rb);
    wr_en = we; wr_addr = ADDR_W'(wa); wr_data = DATA_W'(wd);
    iss_en = ie; iss_addr = ADDR_W'(ia);
    @(negedge clk);
  endtask

  task automatic mid_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_ra_data", 32'(ra_data), 0);
    chk("rst_rb_data", 32'(rb_data), 0);
    chk("rst_ra_busy", 32'(ra_busy), 0);
    chk("rst_rb_busy", 32'(rb_busy), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Write then read, zero register on B
    step(0, 0, 0, 1, 3, 'h1234, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_ra", 32'(ra_data), 'h1234);
    chk("t2_rb", 32'(rb_data), 0);

    // Bypass of same-cycle writeback
    step(1, 5, 3, 1, 5, 'hBEEF, 0, 0);
    chk("t3_ra_before", 32'(ra_data), 'h1234);
    step(0, 5, 0, 0, 0, 0, 0, 0);
    chk("t3_ra_bypass", 32'(ra_data), 'hBEEF);
    chk("t3_rb", 32'(rb_data), 'h1234);

    // Scoreboard set, reject, clear
    step(0, 7, 0, 0, 0, 0, 1, 7);
    chk("t4_iss1", 32'(iss_ok), 1);
    step(0, 7, 0, 0, 0, 0, 1, 7);
    chk("t4_iss2", 32'(iss_ok), 0);
    chk("t4_busy", 32'(ra_busy), 1);
    step(0, 7, 0, 1, 7, 'h0042, 0, 0);
    chk("t4_busy_wb", 32'(ra_busy), 0);
    step(1, 7, 0, 0, 0, 0, 0, 0);
    chk("t4_busy_clr", 32'(ra_busy), 0);
    step(0, 7, 0, 0, 0, 0, 0, 0);
    chk("t4_data", 32'(ra_data), 'h0042);

    // Collision: writeback and issue to the same busy register
    step(0, 0, 0, 0, 0, 0, 1, 9);
    step(1, 9, 0, 1, 9, 'h00AA, 1, 9);
    chk("t5_iss", 32'(iss_ok), 1);
    step(0, 9, 0, 0, 0, 0, 0, 0);
    chk("t5_busy", 32'(ra_busy), 1);
    chk("t5_data", 32'(ra_data), 'h00AA);

    // Asynchronous reset with r9 busy and nonzero read data
    mid_reset();
    step(0, 9, 3, 0, 0, 0, 0, 0);
    chk("t1_busy_after", 32'(ra_busy), 0);
    step(1, 9, 3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_r3_cleared", 32'(rb_data), 0);

    // Zero register and out-of-range address
    step(1, 3, 3, 1, 3, 'h5555, 0, 0);
    step(0, 0, 0, 1, 0, 'hFFFF, 1, 0);
    chk("t6_iss_zero", 32'(iss_ok), 1);
    step(0, 0, NUM_REGS, 1, NUM_REGS, 'hFFFF, 1, NUM_REGS);
    chk("t6_iss_oor", 32'(iss_ok), 1);
    step(1, 0, NUM_REGS, 0, 0, 0, 1, NUM_REGS);
    chk("t6_iss_oor2", 32'(iss_ok), 1);
    chk("t6_rb_busy", 32'(rb_busy), 0);
    chk("t6_ra_busy", 32'(ra_busy), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_ra", 32'(ra_data), 0);
    chk("t6_rb", 32'(rb_data), 0);

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) mid_reset();
      step(bit'($urandom_range(0, 3) != 0), $urandom_range(0, 31), $urandom_range(0, 31),
           bit'($urandom_range(0, 2) == 0), $urandom_range(0, 31), $urandom_range(0, 65535),
           bit'($urandom_range(0, 2) == 0), $urandom_range(0, 31));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
